// File: rtl/mac_operand_sequencer_if.sv
// Byte stream handshake feeding the MAC operand sequencer.
// master drives bytes, slave accepts them on s_valid & s_ready.
interface mac_operand_sequencer_if;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/mac_operand_sequencer.sv
// Steers a byte stream into the dual MAC operand registers, then flushes
// the MAC and flags result bytes. Optional abort port: MAC_SEQ_ABORT_EN.
module mac_operand_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] num_sets,
   mac_operand_sequencer_if.slave strm,
   output logic [7:0]       mac_in,
   output logic [3:0]       mac_ld,
   output logic             mac_clken,
   output logic             mac_clr,
   output logic             piso_ld,
   output logic             out_valid,
   output logic             out_sel,
   output logic             busy,
   output logic             done
`ifdef MAC_SEQ_ABORT_EN
   ,
   input  logic             abort
`endif
);

   typedef enum logic [3:0] {
      IDLE, CLEAR, FETCH, STROBE, STEP, ZERO, ZSTROBE,
      FLUSH0, FLUSH1, CAPTURE, LOAD, OUT0, OUT1, ABORT
   } state_t;

   state_t           state, nxt;
   logic [1:0]       k;
   logic [CNT_W-1:0] set_cnt;
   logic [CNT_W-1:0] n_last;
   logic             kill;
   logic             take;
   logic             last;

`ifdef MAC_SEQ_ABORT_EN
   assign kill = abort && (state != IDLE) && (state != ABORT);
`else
   assign kill = 1'b0;
`endif

   // abort wins over a pending byte, so the handshake is masked
   assign take = (state == FETCH) && strm.s_valid && !kill;
   assign last = (set_cnt == n_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt          = state;
      strm.s_ready = 1'b0;
      mac_ld       = 4'b0000;
      mac_clken    = 1'b0;
      mac_clr      = 1'b0;
      piso_ld      = 1'b0;
      out_valid    = 1'b0;
      out_sel      = 1'b0;
      done         = 1'b0;
      busy         = (state != IDLE) && (state != ABORT);
      unique case (state)
         IDLE:    if (start) nxt = CLEAR;
         CLEAR:   begin mac_clr = 1'b1; nxt = FETCH; end
         FETCH:   begin
            strm.s_ready = !kill;
            if (take) nxt = STROBE;
         end
         STROBE:  begin
            mac_ld = 4'b0001 << k;
            nxt    = (k == 2'd3) ? STEP : FETCH;
         end
         STEP:    begin
            mac_clken = 1'b1;
            nxt       = last ? ZERO : FETCH;
         end
         ZERO:    nxt = ZSTROBE;
         ZSTROBE: begin mac_ld = 4'b1111; nxt = FLUSH0; end
         FLUSH0:  begin mac_clken = 1'b1; nxt = FLUSH1; end
         FLUSH1:  begin mac_clken = 1'b1; nxt = CAPTURE; end
         CAPTURE: nxt = LOAD;
         LOAD:    begin piso_ld = 1'b1; nxt = OUT0; end
         OUT0:    begin
            out_valid = 1'b1;
            out_sel   = 1'b1;
            nxt       = OUT1;
         end
         OUT1:    begin
            out_valid = 1'b1;
            done      = 1'b1;
            nxt       = IDLE;
         end
         ABORT:   begin mac_clr = 1'b1; nxt = IDLE; end
         default: nxt = IDLE;
      endcase
      if (kill) nxt = ABORT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mac_in  <= '0;
         k       <= '0;
         set_cnt <= '0;
         n_last  <= '0;
      end else begin
         if (state == IDLE && start)
            n_last <= (num_sets == '0) ? '0 : num_sets - CNT_W'(1);
         if (state == CLEAR) begin
            k       <= '0;
            set_cnt <= '0;
         end
         if (take) mac_in <= strm.s_data;
         if (state == STROBE && k != 2'd3) k <= k + 2'd1;
         if (state == STEP && !last) begin
            set_cnt <= set_cnt + CNT_W'(1);
            k       <= '0;
         end
         if (state == ZERO) mac_in <= '0;
         if (kill) mac_in <= '0;
      end
   end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer; cycle 0 is the start cycle.
// A small MAC model accumulates operands captured on mac_ld/mac_clken.
module tb_mac_operand_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] num_sets;
   logic [7:0] mac_in;
   logic [3:0] mac_ld;
   logic       mac_clken, mac_clr, piso_ld;
   logic       out_valid, out_sel, busy, done;
`ifdef MAC_SEQ_ABORT_EN
   logic       abort;
`endif

   mac_operand_sequencer_if strm ();

   mac_operand_sequencer #(.CNT_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .num_sets  (num_sets),
      .strm      (strm.slave),
      .mac_in    (mac_in),
      .mac_ld    (mac_ld),
      .mac_clken (mac_clken),
      .mac_clr   (mac_clr),
      .piso_ld   (piso_ld),
      .out_valid (out_valid),
      .out_sel   (out_sel),
      .busy      (busy),
      .done      (done)
`ifdef MAC_SEQ_ABORT_EN
      ,
      .abort     (abort)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int rel;
   int viol;
   int acc1, acc2;
   int ld_q[$], ldd_q[$], ck_q[$], clr_q[$];
   int piso_q[$], ov_q[$], os_q[$], done_q[$];
   logic [7:0] bq[$];
   logic [7:0] opnd[4];
   logic [7:0] prev_in;
   logic [3:0] prev_ld;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int qg(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      rel = cyc - t0;
      if (mac_ld != 4'h0) begin
         ld_q.push_back(int'(mac_ld));
         ldd_q.push_back(int'(mac_in));
         if (mac_ld != 4'hF && $countones(mac_ld) != 1) viol++;
         for (int i = 0; i < 4; i++)
            if (mac_ld[i]) opnd[i] = mac_in;
      end
      if (prev_ld != 4'h0 && mac_in !== prev_in) viol++;
      if (mac_clken) begin
         ck_q.push_back(rel);
         acc1 += int'(opnd[0]) * int'(opnd[1]);
         acc2 += int'(opnd[2]) * int'(opnd[3]);
      end
      if (mac_clr) clr_q.push_back(rel);
      if (piso_ld) piso_q.push_back(rel);
      if (out_valid) begin
         ov_q.push_back(rel);
         os_q.push_back(int'(out_sel));
      end
      if (done) done_q.push_back(rel);
      prev_in = mac_in;
      prev_ld = mac_ld;
   end

   // runs one job; returns the first cycle busy is seen low
   task automatic run_job(input int n, input int stall_at,
                          input int stall_len, input int restart_at,
                          input int abort_at, output int end_c);
      int   bi, stl;
      logic fire;
      @(posedge clk);
      ld_q.delete(); ldd_q.delete(); ck_q.delete(); clr_q.delete();
      piso_q.delete(); ov_q.delete(); os_q.delete(); done_q.delete();
      viol = 0; acc1 = 0; acc2 = 0;
      for (int i = 0; i < 4; i++) opnd[i] = 8'h00;
      @(negedge clk);
      num_sets = 8'(n);
      start = 1'b1;
      t0 = cyc;
      strm.s_valid = 1'b0;
      bi = 0; stl = 0; fire = 1'b0; end_c = -1;
      for (int c = 1; c < 600; c++) begin
         @(negedge clk);
         if (fire) bi++;
         start = 1'b0;
`ifdef MAC_SEQ_ABORT_EN
         abort = 1'b0;
`endif
         if (!busy) begin
            end_c = c;
            break;
         end
         start = (c == restart_at);
`ifdef MAC_SEQ_ABORT_EN
         abort = (c == abort_at);
`endif
         if (bi < bq.size() && bi == stall_at && stl < stall_len
             && strm.s_ready) begin
            strm.s_valid = 1'b0;
            stl++;
         end else if (bi < bq.size()) begin
            strm.s_valid = 1'b1;
            strm.s_data  = bq[bi];
         end else begin
            strm.s_valid = 1'b0;
         end
         #1;
         fire = strm.s_valid && strm.s_ready;
      end
      strm.s_valid = 1'b0;
      if (end_c < 0) chk("timeout", 0, 1);
      repeat (2) @(negedge clk);
      #1;
      chk("ld_rules", viol, 0);
      if (abort_at < 0) chk("bytes_used", bi, bq.size());
   endtask

   function automatic logic [31:0] outs();
      return {busy, done, out_valid, out_sel, piso_ld, mac_clr,
              mac_clken, mac_ld, mac_in, strm.s_ready};
   endfunction

   int ec;
   int exp_ld[5] = '{1, 2, 4, 8, 15};
   int exp_d[5]  = '{3, 5, 2, 7, 0};

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      num_sets = 8'd0;
      strm.s_valid = 1'b0;
      strm.s_data  = 8'h00;
`ifdef MAC_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      #12;
      chk("rst_outs", outs(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // reset mid-FETCH
      @(negedge clk);
      num_sets = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("fetch_ready", int'(strm.s_ready), 1);
      #2 rst_n = 1'b0;
      #1 chk("midrst_outs", outs(), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // single set, stream always valid
      bq = '{8'd3, 8'd5, 8'd2, 8'd7};
      run_job(1, -1, 0, -1, -1, ec);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("t2_ld%0d", i), qg(ld_q, i), exp_ld[i]);
         chk($sformatf("t2_d%0d", i), qg(ldd_q, i), exp_d[i]);
      end
      chk("t2_ldn", ld_q.size(), 5);
      chk("t2_ckn", ck_q.size(), 3);
      chk("t2_ck0", qg(ck_q, 0), 10);
      chk("t2_ck1", qg(ck_q, 1), 13);
      chk("t2_ck2", qg(ck_q, 2), 14);
      chk("t2_clr", qg(clr_q, 0), 1);
      chk("t2_piso", qg(piso_q, 0), 16);
      chk("t2_done", qg(done_q, 0), 18);
      chk("t2_ov0", qg(ov_q, 0), 17);
      chk("t2_sel0", qg(os_q, 0), 1);
      chk("t2_ov1", qg(ov_q, 1), 18);
      chk("t2_sel1", qg(os_q, 1), 0);
      chk("t2_acc1", acc1, 15);
      chk("t2_acc2", acc2, 14);
      chk("t2_idle", ec, 19);

      // two sets of 0xFF
      bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      run_job(2, -1, 0, -1, -1, ec);
      chk("t3_ldn", ld_q.size(), 9);
      chk("t3_ckn", ck_q.size(), 4);
      chk("t3_ck1", qg(ck_q, 1), 19);
      chk("t3_ov0", qg(ov_q, 0), 26);
      chk("t3_sel0", qg(os_q, 0), 1);
      chk("t3_ov1", qg(ov_q, 1), 27);
      chk("t3_sel1", qg(os_q, 1), 0);
      chk("t3_done", qg(done_q, 0), 27);
      chk("t3_byte_m2", (acc2 >> 9) & 255, 8'hFE);
      chk("t3_byte_m1", (acc1 >> 9) & 255, 8'hFE);

      // three-cycle stall before the third byte
      bq = '{8'd3, 8'd5, 8'd2, 8'd7};
      run_job(1, 2, 3, -1, -1, ec);
      chk("t4_ldn", ld_q.size(), 5);
      chk("t4_ld2", qg(ld_q, 2), 4);
      chk("t4_d2", qg(ldd_q, 2), 2);
      chk("t4_ck0", qg(ck_q, 0), 13);
      chk("t4_piso", qg(piso_q, 0), 19);
      chk("t4_done", qg(done_q, 0), 21);

      // num_sets=0 runs one set; start while busy ignored
      bq = '{8'd9, 8'd4, 8'd6, 8'd1};
      run_job(0, -1, 0, 5, -1, ec);
      chk("t5_done", qg(done_q, 0), 18);
      chk("t5_donen", done_q.size(), 1);
      chk("t5_clrn", clr_q.size(), 1);
      chk("t5_acc1", acc1, 36);
      chk("t5_acc2", acc2, 6);
      chk("t5_busy", int'(busy), 0);

`ifdef MAC_SEQ_ABORT_EN
      // abort during the first flush cycle
      bq = '{8'd3, 8'd5, 8'd2, 8'd7};
      run_job(1, -1, 0, -1, 13, ec);
      chk("t6_idle", ec, 14);
      chk("t6_clrn", clr_q.size(), 2);
      chk("t6_clr", qg(clr_q, 1), 14);
      chk("t6_piso", piso_q.size(), 0);
      chk("t6_done", done_q.size(), 0);
      chk("t6_outs", outs(), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
